parking_lot_entry_ctrl: RTL and testbench
=========================================

// Module: parking_lot_entry_ctrl
// PURPOSE
//  Entry-side controller for the N-slot parking lot; the counterpart of the exit decoder.
//  Tracks slot occupancy and handles entry requests: it allocates the lowest-numbered
//  free slot and returns its binary number on park_number.
//  It also accepts one-hot exit locations to free slots and reports full, empty and free count.
//  Slot n maps to location bit (N_SLOTS-1-n): slot 0 = MSB, same one-hot map as the exit path.
// PARAMETERS
//  N_SLOTS  8  number of parking slots (power of two, >=2)
//  NUM_W    3  width of park_number, log2(N_SLOTS)
// PORTS
//  clk            in   1        single clock, all state on rising edge
//  reset          in   1        synchronous, active-high reset
//  entry_req      in   1        car requests entry; sampled only in IDLE
//  exit_valid     in   1        exit_location valid this cycle
//  exit_location  in   N_SLOTS  one-hot location of slot being vacated
//  entry_grant    out  1        1-cycle pulse: slot allocated, park_number valid
//  entry_deny     out  1        1-cycle pulse: lot full, request refused
//  park_number    out  NUM_W    allocated slot number; held until next grant
//  occupancy      out  N_SLOTS  registered occupancy map, bit set = occupied
//  free_count     out  NUM_W+1  number of free slots, 0..N_SLOTS
//  full           out  1        free_count == 0
//  empty          out  1        free_count == N_SLOTS
//  exit_err       out  1        1-cycle pulse: illegal exit request
// BEHAVIOUR
//  Reset (reset=1 at an edge): state=IDLE, occupancy=0, free_count=N_SLOTS, park_number=0.
//   Also entry_grant=entry_deny=exit_err=0, empty=1, full=0. Reset overrides every other input.
//  FSM states: IDLE, GRANT, DENY.
//   IDLE & entry_req & !full -> GRANT. On that edge: park_number <= lowest n with occupancy[N-1-n]==0.
//    On the same edge that occupancy bit is set.
//   IDLE & entry_req & full  -> DENY. occupancy and park_number are unchanged.
//   GRANT -> IDLE. entry_grant=1 only while in GRANT.
//   DENY  -> IDLE. entry_deny=1 only while in DENY.
//   entry_req is ignored in GRANT/DENY. A req still high on return to IDLE is a new request.
//  Latency: req high at edge k -> grant/deny visible for exactly the cycle after edge k.
//   Max throughput is one request per 2 cycles.
//  full/empty/free_count are derived from the registered occupancy map.
//   They reflect the post-update value one cycle after a change.
//  Exit: processed in any state when exit_valid=1.
//   Legal exit = exit_location exactly one-hot and its slot currently occupied. A legal exit clears that bit.
//   Illegal exit = zero bits set, more than one bit set, or slot already free.
//    Effect: occupancy unchanged; exit_err pulses the next cycle.
//   exit_location is ignored when exit_valid=0.
//  Simultaneous allocation and exit on one edge:
//   Allocation and full use occupancy before the edge, so a slot freed on the same edge is not reused.
//   If the lot is full and the exit is legal, the request is denied and the exit frees its slot.
//   If exit targets the slot being allocated, the slot was free, so the exit is illegal: bit ends set, exit_err=1.
//  free_count = popcount of ~occupancy.
//   It never underflows or overflows, because allocation is blocked when full and illegal releases are rejected.
//  Reset mid-GRANT/DENY aborts the pulse: next cycle is IDLE with all outputs at reset values.
// TESTING
//  1 reset, entry_req 1 cycle -> entry_grant pulse 1 cycle later; park_number=0, occupancy=8'b10000000, free_count=7
//  2 8 sequential requests -> park_number 0..7 in order, occupancy=8'hFF, full=1; 9th req -> entry_deny, no grant
//  3 full lot, exit_location=8'b00010000 -> occupancy=8'hEF; next req -> park_number=3, occupancy=8'hFF
//  4 exit_location=8'b00000000, 8'b00000011, or free slot -> exit_err pulse, occupancy unchanged
//  5 full lot, entry_req with legal exit same edge -> entry_deny, slot freed, free_count=1; next req granted
//  6 reset asserted during GRANT with 5 slots occupied -> occupancy=0, free_count=8, empty=1, no grant pulse

Source files
------------

// File: rtl/parking_lot_entry_ctrl.sv
// Entry-side controller for an N-slot parking lot: allocates the lowest free slot,
// frees slots from one-hot exit locations, and reports occupancy, free count, full and empty.
module parking_lot_entry_ctrl #(
    parameter int N_SLOTS = 8,
    parameter int NUM_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entry_req,
    input  logic               exit_valid,
    input  logic [N_SLOTS-1:0] exit_location,
    output logic               entry_grant,
    output logic               entry_deny,
    output logic [NUM_W-1:0]   park_number,
    output logic [N_SLOTS-1:0] occupancy,
    output logic [NUM_W:0]     free_count,
    output logic               full,
    output logic               empty,
    output logic               exit_err,
    output logic [1:0]         state_dbg
);

    // Request handshake: entry_req is a level sampled only in IDLE; each accepted
    // request answers with exactly one single-cycle entry_grant or entry_deny pulse.
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DENY = 2'd2} state_t;

    state_t             state, state_next;
    logic [N_SLOTS-1:0] occ_next;
    logic [NUM_W-1:0]   alloc_num;
    logic [N_SLOTS-1:0] alloc_bit;
    logic               alloc_now;
    logic               exit_onehot;
    logic               exit_legal;
    logic               exit_illegal;
    logic [NUM_W:0]     free_cnt;

    // Lowest-numbered free slot; slot n lives at location bit N_SLOTS-1-n.
    always_comb begin
        alloc_num = '0;
        alloc_bit = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[N_SLOTS-1-i]) begin
                alloc_num = NUM_W'(i);
                alloc_bit = '0;
                alloc_bit[N_SLOTS-1-i] = 1'b1;
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            free_cnt = free_cnt + {{NUM_W{1'b0}}, ~occupancy[i]};
        end
    end

    assign free_count = free_cnt;
    assign full       = (free_cnt == '0);
    assign empty      = (free_cnt == (NUM_W+1)'(N_SLOTS));

    assign exit_onehot  = (exit_location != '0) &&
                          ((exit_location & (exit_location - N_SLOTS'(1))) == '0);
    assign exit_legal   = exit_valid && exit_onehot && ((occupancy & exit_location) != '0);
    assign exit_illegal = exit_valid && !exit_legal;

    always_comb begin
        state_next = state;
        alloc_now  = 1'b0;
        case (state)
            IDLE: begin
                if (entry_req) begin
                    if (full) begin
                        state_next = DENY;
                    end else begin
                        state_next = GRANT;
                        alloc_now  = 1'b1;
                    end
                end
            end
            GRANT:   state_next = IDLE;
            DENY:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An exit hitting the slot being allocated is illegal (slot was free), so clear-then-set is safe.
    always_comb begin
        occ_next = occupancy;
        if (exit_legal) begin
            occ_next = occ_next & ~exit_location;
        end
        if (alloc_now) begin
            occ_next = occ_next | alloc_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            occupancy   <= '0;
            park_number <= '0;
            exit_err    <= 1'b0;
        end else begin
            state     <= state_next;
            occupancy <= occ_next;
            exit_err  <= exit_illegal;
            if (alloc_now) begin
                park_number <= alloc_num;
            end
        end
    end

    assign entry_grant = (state == GRANT);
    assign entry_deny  = (state == DENY);
    assign state_dbg   = state;

endmodule

// File: tb/tb_parking_lot_entry_ctrl.sv
// Directed bench for parking_lot_entry_ctrl: allocation order, deny on full,
// legal/illegal exits, same-edge allocate/exit interactions and reset abort.
module tb_parking_lot_entry_ctrl;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_valid;
    logic [7:0] exit_location;
    logic       entry_grant;
    logic       entry_deny;
    logic [2:0] park_number;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       empty;
    logic       exit_err;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_occ;

    parking_lot_entry_ctrl #(.N_SLOTS(8), .NUM_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_valid   (exit_valid),
        .exit_location(exit_location),
        .entry_grant  (entry_grant),
        .entry_deny   (entry_deny),
        .park_number  (park_number),
        .occupancy    (occupancy),
        .free_count   (free_count),
        .full         (full),
        .empty        (empty),
        .exit_err     (exit_err),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request cycle followed by the return-to-IDLE cycle.
    task automatic request_grant(input string tag, input logic [2:0] exp_num);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        exp_occ = exp_occ | (8'h80 >> exp_num);
        chk({tag, "_grant"}, 32'(entry_grant), 32'd1);
        chk({tag, "_deny"},  32'(entry_deny),  32'd0);
        chk({tag, "_num"},   32'(park_number), 32'(exp_num));
        chk({tag, "_occ"},   32'(occupancy),   32'(exp_occ));
        tick();
        chk({tag, "_grant_end"}, 32'(entry_grant), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        entry_req     = 1'b0;
        exit_valid    = 1'b0;
        exit_location = 8'h00;
        exp_occ       = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_occ",   32'(occupancy),   32'h00);
        chk("rst_free",  32'(free_count),  32'd8);
        chk("rst_empty", 32'(empty),       32'd1);
        chk("rst_full",  32'(full),        32'd0);
        chk("rst_grant", 32'(entry_grant), 32'd0);
        chk("rst_deny",  32'(entry_deny),  32'd0);
        chk("rst_err",   32'(exit_err),    32'd0);
        chk("rst_num",   32'(park_number), 32'd0);
        chk("rst_state", 32'(state_dbg),   32'd0);

        // First request: slot 0, MSB of the map.
        request_grant("t1", 3'd0);
        chk("t1_free",  32'(free_count), 32'd7);
        chk("t1_empty", 32'(empty),      32'd0);

        // Fill remaining slots in order.
        for (int i = 1; i < 8; i++) begin
            request_grant($sformatf("t2_%0d", i), 3'(i));
        end
        chk("t2_occ",  32'(occupancy),  32'hFF);
        chk("t2_full", 32'(full),       32'd1);
        chk("t2_free", 32'(free_count), 32'd0);

        // Ninth request is refused.
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("t2_deny",       32'(entry_deny),  32'd1);
        chk("t2_deny_grant", 32'(entry_grant), 32'd0);
        chk("t2_deny_occ",   32'(occupancy),   32'hFF);
        chk("t2_deny_num",   32'(park_number), 32'd7);
        tick();
        chk("t2_deny_end",   32'(entry_deny),  32'd0);

        // Free slot 3 and reclaim it.
        exit_valid = 1'b1; exit_location = 8'b0001_0000;
        tick();
        exit_valid = 1'b0; exit_location = 8'h00;
        exp_occ = 8'hEF;
        chk("t3_occ",  32'(occupancy),  32'hEF);
        chk("t3_err",  32'(exit_err),   32'd0);
        chk("t3_free", 32'(free_count), 32'd1);
        chk("t3_full", 32'(full),       32'd0);
        request_grant("t3", 3'd3);
        chk("t3_occ_full", 32'(occupancy), 32'hFF);

        // Free slot 0, then a set of illegal exits.
        exit_valid = 1'b1; exit_location = 8'h80;
        tick();
        exit_valid = 1'b0;
        exp_occ = 8'h7F;
        chk("t4_free0_occ", 32'(occupancy), 32'h7F);

        exit_valid = 1'b1; exit_location = 8'h00;
        tick();
        exit_valid = 1'b0;
        chk("t4_zero_err", 32'(exit_err),  32'd1);
        chk("t4_zero_occ", 32'(occupancy), 32'h7F);
        tick();
        chk("t4_err_end",  32'(exit_err),  32'd0);

        exit_valid = 1'b1; exit_location = 8'b0000_0011;
        tick();
        exit_valid = 1'b0;
        chk("t4_two_err", 32'(exit_err),  32'd1);
        chk("t4_two_occ", 32'(occupancy), 32'h7F);

        exit_valid = 1'b1; exit_location = 8'h80;
        tick();
        exit_valid = 1'b0;
        chk("t4_free_err", 32'(exit_err),  32'd1);
        chk("t4_free_occ", 32'(occupancy), 32'h7F);

        exit_location = 8'h01;
        tick();
        exit_location = 8'h00;
        chk("t4_novalid_err", 32'(exit_err),  32'd0);
        chk("t4_novalid_occ", 32'(occupancy), 32'h7F);

        // Refill, then request with a legal exit on the same edge while full.
        request_grant("t5_fill", 3'd0);
        entry_req = 1'b1; exit_valid = 1'b1; exit_location = 8'h01;
        tick();
        entry_req = 1'b0; exit_valid = 1'b0; exit_location = 8'h00;
        exp_occ = 8'hFE;
        chk("t5_deny",  32'(entry_deny),  32'd1);
        chk("t5_grant", 32'(entry_grant), 32'd0);
        chk("t5_occ",   32'(occupancy),   32'hFE);
        chk("t5_free",  32'(free_count),  32'd1);
        chk("t5_err",   32'(exit_err),    32'd0);
        tick();
        request_grant("t5_next", 3'd7);

        // Exit aimed at the slot being allocated is illegal; the bit still ends set.
        exit_valid = 1'b1; exit_location = 8'h01;
        tick();
        exit_valid = 1'b0;
        chk("t5b_free7", 32'(occupancy), 32'hFE);
        entry_req = 1'b1; exit_valid = 1'b1; exit_location = 8'h01;
        tick();
        entry_req = 1'b0; exit_valid = 1'b0; exit_location = 8'h00;
        chk("t5b_grant", 32'(entry_grant), 32'd1);
        chk("t5b_num",   32'(park_number), 32'd7);
        chk("t5b_occ",   32'(occupancy),   32'hFF);
        chk("t5b_err",   32'(exit_err),    32'd1);
        tick();

        // Reset aborts a grant in progress.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_occ = 8'h00;
        chk("t6_pre_occ", 32'(occupancy), 32'h00);
        for (int i = 0; i < 4; i++) begin
            request_grant($sformatf("t6_%0d", i), 3'(i));
        end
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("t6_in_grant", 32'(entry_grant), 32'd1);
        chk("t6_in_occ",   32'(occupancy),   32'hF8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_grant", 32'(entry_grant), 32'd0);
        chk("t6_occ",   32'(occupancy),   32'h00);
        chk("t6_free",  32'(free_count),  32'd8);
        chk("t6_empty", 32'(empty),       32'd1);
        chk("t6_num",   32'(park_number), 32'd0);
        chk("t6_state", 32'(state_dbg),   32'd0);
        tick();
        chk("t6_grant_after", 32'(entry_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
